// File: rtl/stack_sequencer_if.sv
// Host/CPU-side signal bundle for the stack calculator program sequencer.
// master: the host that loads and starts programs; slave: the sequencer itself.
interface stack_sequencer_if #(
  parameter int unsigned ADDR_W = 4
) ();
  logic              load_we;
  logic              load_clr;
  logic [3:0]        load_data;
  logic              start;
  logic              cpu_rst;
  logic [3:0]        cpu_inbits;
  logic [ADDR_W-1:0] pc;
  logic              load_full;
  logic              busy;
  logic              done;
  logic              seq_err;

  modport master (
    output load_we, load_clr, load_data, start,
    input  cpu_rst, cpu_inbits, pc, load_full, busy, done, seq_err
  );

  modport slave (
    input  load_we, load_clr, load_data, start,
    output cpu_rst, cpu_inbits, pc, load_full, busy, done, seq_err
  );
endinterface

// File: rtl/stack_sequencer.sv
// Program sequencer for the stack calculator CPU: holds a small nibble program
// loaded serially by the host, then replays it as the CPU's inbits stream with
// opcode in the fetch cycle, operand in the first execute cycle, and 0x0 padding.
// Optional feature macro SEQ_LOOP_EN: END or pc overflow wraps to pc=0 and keeps
// running instead of entering DONE.
module stack_sequencer #(
  parameter int unsigned PROG_DEPTH = 16,
  parameter int unsigned ADDR_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  stack_sequencer_if.slave       bus
);

  localparam int unsigned NIB_W = 4;
  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned CNT_W = 2;
  localparam logic [NIB_W-1:0] OP_END = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CPURST,
    S_FETCH,
    S_OPERAND,
    S_WAIT,
    S_DONE
  } state_e;

  // Opcodes that carry an operand nibble in the first execute cycle.
  function automatic logic has_operand(input logic [NIB_W-1:0] op);
    case (op)
      4'h1, 4'h6, 4'h7, 4'h8: has_operand = 1'b1;
      default:                has_operand = 1'b0;
    endcase
  endfunction

  // Number of CPU execute cycles following the fetch cycle.
  function automatic logic [CNT_W-1:0] exec_cycles(input logic [NIB_W-1:0] op);
    case (op)
      4'h9, 4'hA:                         exec_cycles = CNT_W'(3);
      4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8: exec_cycles = CNT_W'(2);
      default:                            exec_cycles = CNT_W'(1);
    endcase
  endfunction

  state_e             state_q,      state_d;
  logic [ADDR_W-1:0]  pc_q,         pc_d;
  logic [PTR_W-1:0]   ptr_q,        ptr_d;
  logic               load_full_q,  load_full_d;
  logic               cpu_rst_q,    cpu_rst_d;
  logic [NIB_W-1:0]   cpu_inbits_q, cpu_inbits_d;
  logic               busy_q,       busy_d;
  logic               done_q,       done_d;
  logic               seq_err_q,    seq_err_d;
  logic [CNT_W-1:0]   wait_cnt_q,   wait_cnt_d;
  logic               has_op_q,     has_op_d;

  logic [NIB_W-1:0]   store_q [PROG_DEPTH];
  logic               store_we;

  logic               idle_like;
  logic [NIB_W-1:0]   cur_op;
  logic [ADDR_W-1:0]  opnd_addr;
  logic [PTR_W-1:0]   ptr_inc;
  logic [PTR_W-1:0]   pc_sum;
  logic               pc_ovf;
  logic               advance;
  logic               finish;

  // Next-state, load pointer and registered-output computation.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ptr_d        = ptr_q;
    load_full_d  = load_full_q;
    cpu_inbits_d = cpu_inbits_q;
    seq_err_d    = seq_err_q;
    wait_cnt_d   = wait_cnt_q;
    has_op_d     = has_op_q;
    store_we     = 1'b0;
    advance      = 1'b0;
    finish       = 1'b0;

    idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
    cur_op    = store_q[pc_q];
    opnd_addr = pc_q + ADDR_W'(1);
    ptr_inc   = ptr_q + PTR_W'(1);
    pc_sum    = PTR_W'(pc_q) + PTR_W'(1) + PTR_W'(has_op_q);
    pc_ovf    = (pc_sum >= PTR_W'(PROG_DEPTH));

    // Program loading is only accepted while no program is running.
    if (idle_like) begin
      if (bus.load_clr) begin
        ptr_d       = '0;
        load_full_d = 1'b0;
      end else if (bus.load_we && !load_full_q) begin
        store_we    = 1'b1;
        ptr_d       = ptr_inc;
        load_full_d = (ptr_inc == PTR_W'(PROG_DEPTH));
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        cpu_inbits_d = '0;
        if (bus.start) begin
          state_d      = S_CPURST;
          pc_d         = '0;
          seq_err_d    = 1'b0;
        end
      end
      S_CPURST: begin
        state_d      = S_FETCH;
        cpu_inbits_d = store_q[pc_q];
      end
      S_FETCH: begin
        if (cur_op == OP_END) begin
          finish = 1'b1;
        end else begin
          has_op_d   = has_operand(cur_op);
          wait_cnt_d = exec_cycles(cur_op);
          if (has_operand(cur_op)) begin
            state_d = S_OPERAND;
            // An operand past the end of the store is replaced with 0x0.
            if (pc_q == ADDR_W'(PROG_DEPTH - 1)) begin
              cpu_inbits_d = '0;
              seq_err_d    = 1'b1;
            end else begin
              cpu_inbits_d = store_q[opnd_addr];
            end
          end else begin
            state_d      = S_WAIT;
            cpu_inbits_d = '0;
          end
        end
      end
      S_OPERAND: begin
        wait_cnt_d = wait_cnt_q - CNT_W'(1);
        if (wait_cnt_q > CNT_W'(1)) begin
          state_d      = S_WAIT;
          cpu_inbits_d = '0;
        end else begin
          advance = 1'b1;
        end
      end
      S_WAIT: begin
        wait_cnt_d   = wait_cnt_q - CNT_W'(1);
        cpu_inbits_d = '0;
        if (wait_cnt_q <= CNT_W'(1)) begin
          advance = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Instruction boundary: step to the next opcode or end the program.
    if (advance && !pc_ovf) begin
      state_d      = S_FETCH;
      pc_d         = pc_sum[ADDR_W-1:0];
      cpu_inbits_d = store_q[pc_sum[ADDR_W-1:0]];
    end else if (advance || finish) begin
`ifdef SEQ_LOOP_EN
      state_d      = S_FETCH;
      pc_d         = '0;
      cpu_inbits_d = store_q[0];
`else
      state_d      = S_DONE;
      cpu_inbits_d = '0;
`endif
    end

    cpu_rst_d = (state_d == S_CPURST);
    busy_d    = !((state_d == S_IDLE) || (state_d == S_DONE));
    done_d    = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      ptr_q        <= '0;
      load_full_q  <= 1'b0;
      cpu_rst_q    <= 1'b0;
      cpu_inbits_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      seq_err_q    <= 1'b0;
      wait_cnt_q   <= '0;
      has_op_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ptr_q        <= ptr_d;
      load_full_q  <= load_full_d;
      cpu_rst_q    <= cpu_rst_d;
      cpu_inbits_q <= cpu_inbits_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      seq_err_q    <= seq_err_d;
      wait_cnt_q   <= wait_cnt_d;
      has_op_q     <= has_op_d;
    end
  end

  // Program store; contents survive reset and are only defined once loaded.
  always_ff @(posedge clk) begin
    if (store_we) begin
      store_q[ptr_q[ADDR_W-1:0]] <= bus.load_data;
    end
  end

  assign bus.cpu_rst    = cpu_rst_q;
  assign bus.cpu_inbits = cpu_inbits_q;
  assign bus.pc         = pc_q;
  assign bus.load_full  = load_full_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.seq_err    = seq_err_q;

endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
- Program sequencer that drives the 4-bit instruction/operand nibble stream of the stack calculator CPU from a small internal program store.
- Sits between the user pins and the CPU's inbits/rst inputs.
- Presents each opcode in the CPU's fetch cycle and any operand in the first execute cycle. Pads the remaining execute cycles with 0x0 so no cycle is lost or mis-sampled.
- Host loads a program serially, then pulses start.

Parameters:
- PROG_DEPTH, 16, number of nibbles in the program store.
- ADDR_W, 4, width of the load pointer and PC; must satisfy 2^ADDR_W = PROG_DEPTH.

Ports:
- clk  input  1  system clock, shared with the CPU; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- load_we  input  1  write load_data at the load pointer. Honoured only in IDLE or DONE.
- load_clr  input  1  reset the load pointer to 0. Honoured only in IDLE or DONE.
- load_data  input  4  program nibble to store.
- start  input  1  begin execution from address 0. Honoured only in IDLE or DONE.
- cpu_rst  output  1  active-high synchronous reset to the CPU.
- cpu_inbits  output  4  registered nibble driven to the CPU inbits.
- pc  output  ADDR_W  address of the current opcode.
- load_full  output  1  load pointer has stored PROG_DEPTH nibbles.
- busy  output  1  high in any state except IDLE and DONE.
- done  output  1  high in DONE.
- seq_err  output  1  sticky: program ran off the end while an operand was due.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; load pointer=0; pc=0.
  - cpu_rst=0, cpu_inbits=0x0, load_full=0, busy=0, done=0, seq_err=0.
  - Store contents are undefined.
- Load:
  - On load_we, write store[ptr]=load_data and increment ptr.
  - When ptr reaches PROG_DEPTH, set load_full=1; further writes are ignored and ptr does not wrap.
  - load_clr sets ptr=0 and load_full=0. load_clr wins over load_we in the same cycle.
- Opcode classes (CPU opcodes):
  - Operand follows: 0x1, 0x6, 0x7, 0x8.
  - Execute cycles = 3: 0x9, 0xA.
  - Execute cycles = 2: 0x1, 0x2, 0x5, 0x6, 0x7, 0x8.
  - Execute cycles = 1: all other opcodes.
  - 0xF in an opcode position is END.
- State machine, one transition per clk:
  - IDLE/DONE -> CPURST on start. Clears pc and seq_err.
  - CPURST: cpu_rst=1, cpu_inbits=0x0 for exactly 1 cycle -> FETCH.
  - FETCH: cpu_inbits=store[pc].
    - If the opcode is END -> DONE; cpu_inbits=0x0 in DONE.
    - Otherwise load wait_cnt = execute cycles. If an operand follows -> OPERAND, else -> WAIT.
  - OPERAND: cpu_inbits=store[pc+1]; decrement wait_cnt.
    - Hold that value for exactly one cycle. The CPU samples it at posedge and on the following negedge (BINA/REPL/PUSF selector paths).
    - Then -> WAIT if wait_cnt>0, else -> ADVANCE.
  - WAIT: cpu_inbits=0x0; decrement wait_cnt; -> ADVANCE when it reaches 0.
  - ADVANCE (zero-cycle, folded into the transition):
    - Set pc = pc+1+has_operand -> FETCH.
    - If the addition overflows PROG_DEPTH -> DONE.
- Per-instruction length in clk cycles = 1 + execute cycles. Examples: PUSH 3, OUTL 2, MULT 4.
- Operand boundary: if an operand is due at pc=PROG_DEPTH-1, drive 0x0 as the operand, set seq_err=1, and enter DONE after the instruction completes.
- A start while busy is ignored. load_we/load_clr while busy are ignored.
- An async reset mid-program aborts immediately. cpu_rst drops to 0. The CPU state is left as is until the next start issues CPURST.
- cpu_inbits changes only on posedge clk, so it is stable across the CPU's posedge and negedge sampling points.

Optional Feature:
- Macro: SEQ_LOOP_EN.
- Defined: END or pc overflow returns to FETCH at pc=0 without re-issuing CPURST. done never asserts; busy stays 1 until reset. seq_err behaviour is unchanged.
- Undefined: END or overflow enters DONE as described above.

Test Plan:
- Load 1,5,3,F; start -> cycle sequence cpu_rst=1; then cpu_inbits 1,5,0,3,0,F. Then done=1, pc=3, busy=0.
- Load 1,3,1,4,8,0,9,F (PUSH3, PUSH4, ADD, MULT) -> cpu_inbits 1,3,0,1,4,0,8,0,0,9,0,0,0,F. CPU stack top reads 0x7 before MULT.
- Write 17 nibbles with load_we -> load_full=1 after the 16th; the 17th is ignored. load_clr -> load_full=0, ptr=0.
- 15 nibbles 0x0 then 0x1 at address 15 -> seq_err=1, operand driven as 0x0, done=1.
- Assert rst=0 mid-MULT -> all outputs at reset values asynchronously. A new start reissues the 1-cycle cpu_rst.
- With SEQ_LOOP_EN defined, program 3,F -> cpu_inbits repeats 3,0,F,3,0,F...; done stays 0.
